// File: rtl/att_lookup_arbiter.sv
// Round-robin arbiter sharing the single ATT read port among NUM_REQ requesters,
// fixed 2-cycle lookup latency. Define ATT_ARB_STATS_EN to add the stall_cnt_o counter.
module att_lookup_arbiter #(
  parameter int NUM_REQ                    = 4,
  parameter int LITERAL_ADDRESS_WIDTH      = 12,
  parameter int CLAUSE_TABLE_ADDRESS_WIDTH = 11,
  parameter int CLAUSE_COUNT               = 20,
  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                                       clk_i,
  input  logic                                       rst_i,
  input  logic [NUM_REQ-1:0]                         req_valid_i,
  input  logic [NUM_REQ*LITERAL_ADDRESS_WIDTH-1:0]   req_addr_i,
  output logic [NUM_REQ-1:0]                         req_ready_o,
  input  logic                                       cfg_busy_i,
  output logic [LITERAL_ADDRESS_WIDTH-1:0]           att_rd_addr_o,
  input  logic [CLAUSE_TABLE_ADDRESS_WIDTH-1:0]      att_addr_i,
  input  logic [CLAUSE_COUNT-1:0]                    att_mask_i,
  output logic                                       rsp_valid_o,
  output logic [ID_W-1:0]                            rsp_id_o,
  output logic [CLAUSE_TABLE_ADDRESS_WIDTH-1:0]      rsp_addr_o,
  output logic [CLAUSE_COUNT-1:0]                    rsp_mask_o,
  output logic                                       idle_o
`ifdef ATT_ARB_STATS_EN
  ,
  output logic [15:0]                                stall_cnt_o
`endif
);

  localparam int LAW = LITERAL_ADDRESS_WIDTH;

  typedef enum logic [1:0] {RUN, HOLD, DRAIN} state_t;

  state_t          state_q, state_d;
  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic            gnt_vld;
  logic [ID_W-1:0] gnt_id;
  logic [ID_W-1:0] s1_id_q;
  logic [2:1]      vld_pipe;

  // Grant only when the table is stable; reset also masks grants so outputs sit at 0.
  always_comb begin
    gnt_vld       = 1'b0;
    gnt_id        = '0;
    req_ready_o   = '0;
    att_rd_addr_o = '0;
    if (state_q == RUN && !cfg_busy_i && !rst_i) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!gnt_vld && req_valid_i[(int'(rr_ptr_q) + i) % NUM_REQ]) begin
          gnt_vld = 1'b1;
          gnt_id  = ID_W'((int'(rr_ptr_q) + i) % NUM_REQ);
        end
      end
    end
    if (gnt_vld) begin
      req_ready_o[gnt_id] = 1'b1;
      att_rd_addr_o       = req_addr_i[int'(gnt_id)*LAW +: LAW];
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (gnt_vld)
      rr_ptr_d = (gnt_id == ID_W'(NUM_REQ-1)) ? '0 : gnt_id + ID_W'(1);
  end

  // DRAIN gives the ATT one cycle to re-settle after a load before lookups resume.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (cfg_busy_i)  state_d = HOLD;
      HOLD:    if (!cfg_busy_i) state_d = DRAIN;
      DRAIN:   state_d = cfg_busy_i ? HOLD : RUN;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= RUN;
      rr_ptr_q   <= '0;
      vld_pipe   <= '0;
      s1_id_q    <= '0;
      rsp_id_o   <= '0;
      rsp_addr_o <= '0;
      rsp_mask_o <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      vld_pipe <= {vld_pipe[1], gnt_vld};
      s1_id_q  <= gnt_id;
      if (vld_pipe[1]) begin
        rsp_id_o   <= s1_id_q;
        rsp_addr_o <= att_addr_i;
        rsp_mask_o <= att_mask_i;
      end
    end
  end

  assign rsp_valid_o = vld_pipe[2];
  assign idle_o      = !gnt_vld && !vld_pipe[1] && !vld_pipe[2];

`ifdef ATT_ARB_STATS_EN
  always_ff @(posedge clk_i) begin
    if (rst_i)
      stall_cnt_o <= '0;
    else if (|req_valid_i && !gnt_vld && stall_cnt_o != 16'hFFFF)
      stall_cnt_o <= stall_cnt_o + 16'd1;
  end
`endif

endmodule

// File: tb/tb_att_lookup_arbiter.sv
// Directed bench for att_lookup_arbiter with a registered-read ATT model.
module tb_att_lookup_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [47:0] req_addr;
  logic [3:0]  ready;
  logic        busy;
  logic [11:0] att_rd_addr;
  logic [10:0] att_addr;
  logic [19:0] att_mask;
  logic        rsp_valid;
  logic [1:0]  rsp_id;
  logic [10:0] rsp_addr;
  logic [19:0] rsp_mask;
  logic        idle;
  logic [30:0] gen;
`ifdef ATT_ARB_STATS_EN
  logic [15:0] stall_cnt;
`endif

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  att_lookup_arbiter dut (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_addr_i(req_addr),
    .req_ready_o(ready), .cfg_busy_i(busy), .att_rd_addr_o(att_rd_addr),
    .att_addr_i(att_addr), .att_mask_i(att_mask), .rsp_valid_o(rsp_valid),
    .rsp_id_o(rsp_id), .rsp_addr_o(rsp_addr), .rsp_mask_o(rsp_mask), .idle_o(idle)
`ifdef ATT_ARB_STATS_EN
    , .stall_cnt_o(stall_cnt)
`endif
  );

  // ATT contents: entry 5 fixed, others derived from the address; gen models a reload.
  function automatic logic [30:0] att_f(input logic [11:0] a, input logic [30:0] g);
    if (a == 12'h005) att_f = {11'h03A, 20'h00011} ^ g;
    else              att_f = {a[10:0] ^ 11'h2A5, 8'h00, a} ^ g;
  endfunction

  always @(posedge clk) {att_addr, att_mask} <= att_f(att_rd_addr, gen);

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    next_cyc();
    next_cyc();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 4'hF; busy = 1'b0;
    next_cyc();
    @(negedge clk);
    n_chk++; if (ready !== 4'b0000) begin n_fail++; $display("FAIL rst_ready got %b exp 0000", ready); end
    n_chk++; if (att_rd_addr !== 12'h000) begin n_fail++; $display("FAIL rst_rdaddr got %h exp 000", att_rd_addr); end
    next_cyc();
    @(negedge clk);
    n_chk++; if ({rsp_valid, rsp_id, rsp_addr, rsp_mask} !== 34'd0) begin n_fail++;
      $display("FAIL rst_rsp got v=%b id=%0d a=%h m=%h exp all 0", rsp_valid, rsp_id, rsp_addr, rsp_mask); end
    n_chk++; if (idle !== 1'b1) begin n_fail++; $display("FAIL rst_idle got %b exp 1", idle); end
    req_valid = 4'h0;
    next_cyc();
    rst = 1'b0;
    next_cyc();
  endtask

  task automatic test_single();
    req_valid = 4'b0010; req_addr[12 +: 12] = 12'h005;
    @(negedge clk);
    n_chk++; if (ready !== 4'b0010) begin n_fail++; $display("FAIL t1_ready got %b exp 0010", ready); end
    n_chk++; if (att_rd_addr !== 12'h005) begin n_fail++; $display("FAIL t1_rdaddr got %h exp 005", att_rd_addr); end
    n_chk++; if (idle !== 1'b0) begin n_fail++; $display("FAIL t1_idle got %b exp 0", idle); end
    next_cyc();
    req_valid = 4'b0000;
    @(negedge clk);
    n_chk++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL t1_early got %b exp 0", rsp_valid); end
    next_cyc();
    @(negedge clk);
    n_chk++; if ({rsp_valid, rsp_id, rsp_addr, rsp_mask} !== {1'b1, 2'd1, 11'h03A, 20'h00011}) begin n_fail++;
      $display("FAIL t1_rsp got v=%b id=%0d a=%h m=%h exp v=1 id=1 a=03a m=00011", rsp_valid, rsp_id, rsp_addr, rsp_mask); end
    next_cyc();
    @(negedge clk);
    n_chk++; if (rsp_valid !== 1'b0 || idle !== 1'b1) begin n_fail++; $display("FAIL t1_after got v=%b idle=%b exp v=0 idle=1", rsp_valid, idle); end
    next_cyc();
  endtask

  task automatic test_all_req();
    logic [3:0]  exp_rdy;
    logic [1:0]  eid;
    logic [30:0] ed;
    do_reset();
    for (int k = 0; k < 4; k++) req_addr[k*12 +: 12] = 12'h010 + 12'(k);
    for (int c = 0; c < 10; c++) begin
      req_valid = (c < 8) ? 4'hF : 4'h0;
      exp_rdy = (c < 8) ? 4'(1 << (c % 4)) : 4'h0;
      @(negedge clk);
      n_chk++; if (ready !== exp_rdy) begin n_fail++; $display("FAIL t2_ready c=%0d got %b exp %b", c, ready, exp_rdy); end
      if (c >= 2) begin
        eid = 2'((c - 2) % 4);
        ed  = att_f(12'h010 + 12'(eid), 31'd0);
        n_chk++; if ({rsp_valid, rsp_id, rsp_addr, rsp_mask} !== {1'b1, eid, ed}) begin n_fail++;
          $display("FAIL t2_rsp c=%0d got v=%b id=%0d a=%h m=%h exp id=%0d a=%h m=%h", c, rsp_valid, rsp_id,
                   rsp_addr, rsp_mask, eid, ed[30:20], ed[19:0]); end
      end
      next_cyc();
    end
  endtask

  task automatic test_skip_idle();
    logic [3:0] exp_rdy [4];
    logic [1:0] gseq [4];
    exp_rdy = '{4'b0001, 4'b0100, 4'b0001, 4'b0100};
    gseq    = '{2'd0, 2'd2, 2'd0, 2'd2};
    for (int c = 0; c < 6; c++) begin
      req_valid = (c == 0) ? 4'b0001 : (c < 4) ? 4'b0101 : 4'b0000;
      @(negedge clk);
      if (c < 4) begin
        n_chk++; if (ready !== exp_rdy[c]) begin n_fail++; $display("FAIL t3_ready c=%0d got %b exp %b", c, ready, exp_rdy[c]); end
      end
      if (c >= 2) begin
        n_chk++; if (rsp_valid !== 1'b1 || rsp_id !== gseq[c-2]) begin n_fail++;
          $display("FAIL t3_rsp c=%0d got v=%b id=%0d exp v=1 id=%0d", c, rsp_valid, rsp_id, gseq[c-2]); end
      end
      next_cyc();
    end
    next_cyc();
  endtask

  task automatic test_busy();
    logic [3:0]  exp_rdy;
    logic [30:0] ed;
    req_valid = 4'b0010; req_addr[12 +: 12] = 12'h020; req_addr[36 +: 12] = 12'h030;
    @(negedge clk);
    n_chk++; if (ready !== 4'b0010) begin n_fail++; $display("FAIL t4_pre got %b exp 0010", ready); end
    next_cyc();
    gen = 31'h2AAA_5555;
    for (int c = 0; c < 10; c++) begin
      busy = (c <= 4);
      req_valid = (c <= 7) ? 4'b1000 : 4'b0000;
      exp_rdy = (c == 7) ? 4'b1000 : 4'b0000;
      @(negedge clk);
      n_chk++; if (ready !== exp_rdy) begin n_fail++; $display("FAIL t4_ready c=%0d got %b exp %b", c, ready, exp_rdy); end
      if (c == 1) begin
        ed = att_f(12'h020, 31'd0);
        n_chk++; if ({rsp_valid, rsp_id, rsp_addr, rsp_mask} !== {1'b1, 2'd1, ed}) begin n_fail++;
          $display("FAIL t4_prewrite got v=%b id=%0d a=%h m=%h exp id=1 a=%h m=%h", rsp_valid, rsp_id, rsp_addr, rsp_mask, ed[30:20], ed[19:0]); end
      end
      if (c == 2 || c == 8) begin
        n_chk++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL t4_gap c=%0d got %b exp 0", c, rsp_valid); end
      end
      if (c == 4) begin
        n_chk++; if (idle !== 1'b1) begin n_fail++; $display("FAIL t4_idle got %b exp 1", idle); end
      end
      if (c == 9) begin
        ed = att_f(12'h030, gen);
        n_chk++; if ({rsp_valid, rsp_id, rsp_addr, rsp_mask} !== {1'b1, 2'd3, ed}) begin n_fail++;
          $display("FAIL t4_postwrite got v=%b id=%0d a=%h m=%h exp id=3 a=%h m=%h", rsp_valid, rsp_id, rsp_addr, rsp_mask, ed[30:20], ed[19:0]); end
      end
      next_cyc();
    end
    busy = 1'b0;
  endtask

  task automatic test_reset_mid();
    req_valid = 4'b0100;
    @(negedge clk);
    n_chk++; if (ready !== 4'b0100) begin n_fail++; $display("FAIL t5_grant got %b exp 0100", ready); end
    next_cyc();
    req_valid = 4'b0000; rst = 1'b1;
    next_cyc();
    rst = 1'b0; req_valid = 4'hF;
    @(negedge clk);
    n_chk++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL t5_rsp got %b exp 0", rsp_valid); end
    n_chk++; if (ready !== 4'b0001) begin n_fail++; $display("FAIL t5_ptr got %b exp 0001", ready); end
    req_valid = 4'b0000;
    @(posedge clk); #1;
    @(negedge clk);
    n_chk++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL t5_rsp2 got %b exp 0", rsp_valid); end
    next_cyc();
    next_cyc();
    @(negedge clk);
    n_chk++; if (idle !== 1'b1) begin n_fail++; $display("FAIL t5_idle got %b exp 1", idle); end
    next_cyc();
  endtask

`ifdef ATT_ARB_STATS_EN
  task automatic test_stats();
    do_reset();
    @(negedge clk);
    n_chk++; if (stall_cnt !== 16'd0) begin n_fail++; $display("FAIL t6_clr got %0d exp 0", stall_cnt); end
    for (int c = 0; c < 5; c++) begin
      busy = (c <= 2);
      req_valid = (c >= 1) ? 4'b0001 : 4'b0000;
      next_cyc();
    end
    @(negedge clk);
    n_chk++; if (stall_cnt !== 16'd4) begin n_fail++; $display("FAIL t6_cnt got %0d exp 4", stall_cnt); end
    n_chk++; if (ready !== 4'b0001) begin n_fail++; $display("FAIL t6_ready got %b exp 0001", ready); end
    busy = 1'b1;
    for (int c = 0; c < 70000; c++) next_cyc();
    @(negedge clk);
    n_chk++; if (stall_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL t6_sat got %h exp ffff", stall_cnt); end
    busy = 1'b0; req_valid = 4'b0000;
    next_cyc();
  endtask
`endif

  initial begin
    rst = 1'b1; req_valid = 4'h0; req_addr = '0; busy = 1'b0; gen = '0;
    next_cyc();
    test_reset();
    test_single();
    test_all_req();
    test_skip_idle();
    test_busy();
    test_reset_mid();
`ifdef ATT_ARB_STATS_EN
    test_stats();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
